pll_reset_sequencer: RTL and testbench

- Owns bring-up of the system PLL and release of the system resets that depend on it.
- Runs on the free-running 38.4 MHz reference clock, the same clock that feeds the PLL.
- Drives the PLL reset and monitors the PLL's asynchronous locked output. After lock is stable, it releases reset stages in a fixed order. On lock loss, a lock timeout or a software request, it re-asserts all stages.
- Per-domain synchronizers downstream consume the rst_stage outputs.

---
 rtl/pll_reset_sequencer_if.sv | 30 +++
 rtl/pll_reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer_if
//  Description : Status/control bundle between the PLL reset sequencer and
//                its host (lock input, software request, resets, counters).
//  Revision    : 1.0
// ============================================================================
interface pll_reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  locked;
  logic                  sw_reset_req;
  logic                  pll_rst;
  logic [NUM_STAGES-1:0] rst_stage;
  logic                  all_released;
  logic [7:0]            lock_lost_count;
  logic [7:0]            timeout_count;
  logic [2:0]            state;

  modport master (
    output locked, sw_reset_req,
    input  pll_rst, rst_stage, all_released, lock_lost_count, timeout_count, state
  );

  modport slave (
    input  locked, sw_reset_req,
    output pll_rst, rst_stage, all_released, lock_lost_count, timeout_count, state
  );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : PLL bring-up and ordered release of dependent reset stages.
//  Revision    : 1.0
// ============================================================================
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 38400,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_DELAY    = 64,
  parameter int NUM_STAGES     = 3,
  parameter int CNT_W          = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  pll_reset_sequencer_if.slave  bus
);

  localparam int REL_W = $clog2(NUM_STAGES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [REL_W-1:0]      r_nrel;
  logic [REL_W-1:0]      w_nrel_next;
  logic [7:0]            r_lost;
  logic [7:0]            w_lost_next;
  logic [7:0]            r_tmo;
  logic [7:0]            w_tmo_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  w_locked_s;
  logic                  r_pll_rst;
  logic [NUM_STAGES-1:0] r_rst_stage;
  logic [NUM_STAGES-1:0] w_stage_next;
  logic                  r_all_rel;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_nrel      <= '0;
      r_lost      <= '0;
      r_tmo       <= '0;
      r_pll_rst   <= 1'b1;
      r_rst_stage <= '1;
      r_all_rel   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.locked};
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_nrel      <= w_nrel_next;
      r_lost      <= w_lost_next;
      r_tmo       <= w_tmo_next;
      r_pll_rst   <= (w_state_next == S_PLL_RST);
      r_rst_stage <= w_stage_next;
      r_all_rel   <= (w_state_next == S_RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_nrel_next  = r_nrel;
    w_lost_next  = r_lost;
    w_tmo_next   = r_tmo;

    case (r_state)
      S_PLL_RST: begin
        w_nrel_next = '0;
        if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end
      end
      S_WAIT_LOCK: begin
        w_nrel_next = '0;
        // Lock is checked first so it wins against a coincident timeout.
        if (w_locked_s) begin
          w_state_next = S_STABLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_state_next = S_PLL_RST;
          w_cnt_next   = '0;
          w_tmo_next   = r_tmo + {7'd0, (r_tmo != 8'hFF)};
        end
      end
      S_STABLE: begin
        if (!w_locked_s) begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_next = (NUM_STAGES == 1) ? S_RUN : S_RELEASE;
          w_cnt_next   = '0;
          w_nrel_next  = REL_W'(1);
        end
      end
      S_RELEASE: begin
        if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
          w_cnt_next  = '0;
          w_nrel_next = r_nrel + REL_W'(1);
          if (r_nrel == REL_W'(NUM_STAGES - 1)) w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_next = r_cnt;
      end
      default: begin
        w_state_next = S_PLL_RST;
        w_cnt_next   = '0;
        w_nrel_next  = '0;
      end
    endcase

    if ((r_state == S_RELEASE || r_state == S_RUN) && !w_locked_s) begin
      w_state_next = S_WAIT_LOCK;
      w_cnt_next   = '0;
      w_nrel_next  = '0;
      w_lost_next  = r_lost + {7'd0, (r_lost != 8'hFF)};
    end

    // Software request overrides everything, including loss accounting.
    if (bus.sw_reset_req) begin
      w_state_next = S_PLL_RST;
      w_cnt_next   = '0;
      w_nrel_next  = '0;
      w_lost_next  = r_lost;
      w_tmo_next   = r_tmo;
    end
  end

  always_comb begin
    w_stage_next = '1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_stage_next[k] = (k >= int'(w_nrel_next));
    end
  end

  assign bus.pll_rst         = r_pll_rst;
  assign bus.rst_stage       = r_rst_stage;
  assign bus.all_released    = r_all_rel;
  assign bus.lock_lost_count = r_lost;
  assign bus.timeout_count   = r_tmo;
  assign bus.state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reset_sequencer
//  Description : Directed self-checking bench, scaled-down timing parameters.
//  Revision    : 1.0
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int P_RST  = 16;
  localparam int P_TMO  = 400;
  localparam int P_STB  = 64;
  localparam int P_DLY  = 8;
  localparam int P_NSTG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_lost = 0;
  logic seen;
  logic ok;

  pll_reset_sequencer_if #(.NUM_STAGES(P_NSTG)) bus_if ();

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TMO),
    .STABLE_CYCLES (P_STB),
    .STAGE_DELAY   (P_DLY),
    .NUM_STAGES    (P_NSTG),
    .CNT_W         (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick(1);
      if (bus_if.state == s) found = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(bus_if.pll_rst), 1);
    chk({tag, "_stage"}, 32'(bus_if.rst_stage), 7);
    chk({tag, "_allrel"}, 32'(bus_if.all_released), 0);
    chk({tag, "_lost"}, 32'(bus_if.lock_lost_count), 0);
    chk({tag, "_tmo"}, 32'(bus_if.timeout_count), 0);
    chk({tag, "_state"}, 32'(bus_if.state), 0);
  endtask

  initial begin
    bus_if.locked       = 1'b1;
    bus_if.sw_reset_req = 1'b0;
    tick(3);
    chk_reset_vals("in_reset");
    rst = 1'b0;

    // Power-up with lock already present: 16 cycles pll_rst, 1 cycle wait, 64 stable.
    tick(15);
    chk("pll_rst_hold", 32'(bus_if.pll_rst), 1);
    tick(1);
    chk("pll_rst_fall", 32'(bus_if.pll_rst), 0);
    chk("wait_lock", 32'(bus_if.state), 1);
    tick(1);
    chk("stable_enter", 32'(bus_if.state), 2);
    tick(63);
    chk("stable_end", 32'(bus_if.rst_stage), 7);
    tick(1);
    chk("rel0_state", 32'(bus_if.state), 3);
    chk("rel0_stage", 32'(bus_if.rst_stage), 6);
    tick(7);
    chk("rel0_hold", 32'(bus_if.rst_stage), 6);
    tick(1);
    chk("rel1_stage", 32'(bus_if.rst_stage), 4);
    tick(7);
    chk("rel1_allrel", 32'(bus_if.all_released), 0);
    tick(1);
    chk("rel2_stage", 32'(bus_if.rst_stage), 0);
    chk("run_state", 32'(bus_if.state), 4);
    chk("run_allrel", 32'(bus_if.all_released), 1);

    // Lock loss in RUN: stages re-asserted on the third edge.
    bus_if.locked = 1'b0;
    tick(2);
    chk("loss_lat2", 32'(bus_if.rst_stage), 0);
    tick(1);
    exp_lost = 1;
    chk("loss_stage", 32'(bus_if.rst_stage), 7);
    chk("loss_state", 32'(bus_if.state), 1);
    chk("loss_allrel", 32'(bus_if.all_released), 0);
    chk("loss_count", 32'(bus_if.lock_lost_count), 32'(exp_lost));
    bus_if.locked = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 82; i++) begin
      tick(1);
      if (bus_if.pll_rst) seen = 1'b1;
    end
    chk("rerun_release", 32'(bus_if.state), 3);
    tick(1);
    chk("rerun_run", 32'(bus_if.state), 4);
    chk("rerun_no_pllrst", 32'(seen), 0);

    // Software request coincident with synchronized lock loss.
    bus_if.locked = 1'b0;
    tick(2);
    bus_if.sw_reset_req = 1'b1;
    tick(1);
    bus_if.sw_reset_req = 1'b0;
    bus_if.locked = 1'b1;
    chk("sw_state", 32'(bus_if.state), 0);
    chk("sw_pll_rst", 32'(bus_if.pll_rst), 1);
    chk("sw_stage", 32'(bus_if.rst_stage), 7);
    chk("sw_lost", 32'(bus_if.lock_lost_count), 32'(exp_lost));
    tick(15);
    chk("sw_pll_hold", 32'(bus_if.pll_rst), 1);
    tick(1);
    chk("sw_pll_fall", 32'(bus_if.pll_rst), 0);
    tick(1);
    chk("sw_stable", 32'(bus_if.state), 2);

    // One-cycle lock glitch during STABLE restarts the qualification.
    tick(28);
    bus_if.locked = 1'b0;
    tick(1);
    bus_if.locked = 1'b1;
    tick(2);
    chk("glitch_state", 32'(bus_if.state), 1);
    chk("glitch_stage", 32'(bus_if.rst_stage), 7);
    chk("glitch_lost", 32'(bus_if.lock_lost_count), 32'(exp_lost));
    tick(1);
    chk("glitch_restable", 32'(bus_if.state), 2);
    tick(63);
    chk("glitch_full_wait", 32'(bus_if.state), 2);
    tick(1);
    chk("glitch_release", 32'(bus_if.state), 3);
    wait_state(3'd4, 100, ok);
    chk("glitch_run", 32'(ok), 1);

    // Lock absent: each timeout costs 16 + 400 cycles.
    bus_if.locked = 1'b0;
    bus_if.sw_reset_req = 1'b1;
    tick(1);
    bus_if.sw_reset_req = 1'b0;
    tick(15);
    chk("tmo_pll_hold", 32'(bus_if.pll_rst), 1);
    tick(1);
    chk("tmo_wait", 32'(bus_if.state), 1);
    tick(399);
    chk("tmo_not_yet", 32'(bus_if.timeout_count), 0);
    chk("tmo_stage", 32'(bus_if.rst_stage), 7);
    tick(1);
    chk("tmo1_count", 32'(bus_if.timeout_count), 1);
    chk("tmo1_pll_rst", 32'(bus_if.pll_rst), 1);
    tick(16);
    chk("tmo2_wait", 32'(bus_if.state), 1);
    tick(400);
    chk("tmo2_count", 32'(bus_if.timeout_count), 2);
    chk("tmo2_state", 32'(bus_if.state), 0);

    // Lock arriving on the timeout cycle wins.
    tick(16);
    chk("race_wait", 32'(bus_if.state), 1);
    tick(397);
    bus_if.locked = 1'b1;
    tick(2);
    chk("race_pre", 32'(bus_if.state), 1);
    tick(1);
    chk("race_state", 32'(bus_if.state), 2);
    chk("race_tmo", 32'(bus_if.timeout_count), 2);

    // Repeated losses in RELEASE until the counter saturates.
    seen = 1'b1;
    for (int i = 0; i < 264; i++) begin
      wait_state(3'd3, 200, ok);
      if (!ok) seen = 1'b0;
      bus_if.locked = 1'b0;
      tick(3);
      bus_if.locked = 1'b1;
      if (exp_lost < 255) exp_lost++;
      if (i == 253) chk("lost_255", 32'(bus_if.lock_lost_count), 255);
    end
    chk("lost_loop_ok", 32'(seen), 1);
    chk("lost_sat", 32'(bus_if.lock_lost_count), 32'(exp_lost));

    // Asynchronous reset in the middle of RELEASE.
    wait_state(3'd3, 200, ok);
    chk("pre_async", 32'(ok), 1);
    tick(3);
    chk("pre_async_stage", 32'(bus_if.rst_stage), 6);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    tick(2);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
